m_kbd_evq: RTL and testbench
============================

# m_kbd_evq

Parametrised keyboard event queue that succeeds the fixed 16-entry scancode FIFO inside the virtio keyboard device. It parses raw scancode bytes from the PS/2 or CH559 receiver into make/break events and tracks the E0 extended prefix. Events are buffered in a DEPTH-entry queue. The block raises a throttled service request to the micro-controller, and the micro-controller pops one event per request through an explicit handshake. Overflow is counted instead of silently lost.

## Interface
- DEPTH, 16, queue entries; power of two, 4..256
- TICK_BITS, 18, request throttle: a tick occurs when i_mtime[TICK_BITS-1:0]==0
- OVF_W, 8, overflow counter width
- CLK  in  1  single clock
- RST_X  in  1  reset; asynchronous, active-low
- i_rx_we  in  1  receiver byte strobe, one cycle per byte
- i_rx_data  in  8  received scancode byte
- i_mtime  in  64  machine timer
- i_enable  in  1  request gate: CPU mode and init stage complete
- i_flush  in  1  synchronous clear of queue, parser and handshake
- i_pop  in  1  consumer has taken o_head; pops it and ends the outstanding request
- o_req  out  1  one-cycle service request (drives keyboard IRQ/qsel path)
- o_head  out  16  {6'b0, ext, make, code[7:0]} of the oldest event; 0 when empty
- o_count  out  $clog2(DEPTH)+1  entries held
- o_ovf_cnt  out  OVF_W  saturating count of dropped events
- o_pending  out  1  a request has been issued and not yet popped

## Operation
Parser FSM, advancing only on i_rx_we. States are P_IDLE, P_EXT, P_BRK and P_EXT_BRK.
- 0xE0 in any state goes to P_EXT. A repeated or misplaced prefix restarts the sequence.
- 0xF0: P_IDLE goes to P_BRK, P_EXT goes to P_EXT_BRK, and P_BRK / P_EXT_BRK stay where they are.
- Any other byte pushes an event and returns the FSM to P_IDLE.
  - make = 1 from P_IDLE/P_EXT and 0 from P_BRK/P_EXT_BRK.
  - ext = 1 from P_EXT/P_EXT_BRK.

Queue:
- Circular head/tail pointers of $clog2(DEPTH) bits, wrapping naturally. o_count is kept separately so the full state is distinguishable.
- Push when o_count==DEPTH and no pop in the same cycle: the event is dropped and o_ovf_cnt increments, saturating at all-ones.
- Pop with o_count==0 is ignored.
- Push and pop in the same cycle: both take effect and o_count is unchanged. This includes the full case, where the pop frees the slot for the push.

Request/handshake:
- A qualifying cycle needs all of: tick, i_enable=1, o_count!=0 and o_pending=0.
- A qualifying cycle sets o_req for exactly one cycle (the next cycle) and sets o_pending.
- i_pop clears o_pending and pops the head.
  - i_pop without o_pending still pops, which is the CPU-drain path.
  - A new request cannot issue before the next tick after the pop.
- Ticks seen while o_pending=1 are ignored; no request is queued up.
- i_flush has priority over push, pop and request in the same cycle. It zeroes the pointers, o_count, o_pending, o_req and o_ovf_cnt, and returns the parser to P_IDLE.

## Timing
- Reset (RST_X low, asynchronous) clears every output and register to 0: o_req, o_head, o_count, o_ovf_cnt and o_pending.
- Queue storage is not reset.
- Byte on i_rx_we at cycle n:
  - o_count and o_head are updated at n+1.
  - This holds when the queue was empty as well; there is no bypass path.
- Qualifying tick sampled at cycle n: o_req=1 and o_pending=1 at n+1, and o_req=0 at n+2.
- i_pop at cycle n: the new o_head, o_count and o_pending=0 are visible at n+1.
- o_head is registered, or read from a registered head pointer with combinational array read. Either way it must be stable throughout a pending request.

## Structure
- Shared package/define file holds:
  - the prefix constants KBD_PFX_EXT=8'hE0 and KBD_PFX_BRK=8'hF0;
  - the parser state encodings;
  - the event bit positions (EV_MAKE=8, EV_EXT=9).
- One natural sub-module: m_kbd_scan_parser, containing the prefix FSM plus the event output strobe.
- Queue, counter and handshake logic stay in m_kbd_evq.
- Target size is about 200 lines of RTL.

## Test plan
- Byte sequence 1C, F0 1C, E0 75, E0 F0 75, then a pop after each request:
  - o_head sequence must be 0x011C, 0x001C, 0x0375, 0x0275;
  - o_count must return to 0.
- DEPTH=4: push 6 make codes with no pop. Required: o_count=4, o_ovf_cnt=2, and the head is still the first code.
- Full queue with a byte and i_pop in the same cycle: o_count stays 4, and the new event lands at the tail after wrap.
- Two events queued with i_enable=1 and no pop:
  - exactly one o_req pulse across 3 ticks, with o_pending held;
  - after i_pop, the next tick yields a second o_req.
- i_enable=0 while ticks arrive: no o_req. After i_enable rises, o_req follows the next tick.
- Reset or flush mid-operation:
  - Asserting RST_X low asynchronously mid-way through E0 F0 clears all outputs immediately.
  - After release, byte 1C yields 0x011C, with no stale ext/break.
  - i_flush with 3 entries and o_pending=1 gives o_count=0 and o_pending=0 at the next cycle.

Source files
------------

// File: rtl/m_kbd_evq_pkg.sv
`default_nettype none
// ============================================================================
// m_kbd_evq_pkg : shared constants and types for the keyboard event queue
// Rev 1.0 : initial release
// ============================================================================
package m_kbd_evq_pkg;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK = 8'hF0;

  // Bit positions inside a queued event; bits [7:0] carry the scancode.
  localparam int EV_MAKE = 8;
  localparam int EV_EXT  = 9;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_EXT     = 2'd1,
    P_BRK     = 2'd2,
    P_EXT_BRK = 2'd3
  } parse_state_e;

endpackage
`default_nettype wire

// File: rtl/m_kbd_scan_parser.sv
`default_nettype none
// ============================================================================
// m_kbd_scan_parser : E0/F0 prefix tracker turning scancode bytes into events
// Rev 1.0 : initial release
// ============================================================================
module m_kbd_scan_parser
  import m_kbd_evq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       flush,
  input  logic       rx_we,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  output logic       ev_make,
  output logic       ev_ext,
  output logic [7:0] ev_code
);

  parse_state_e state, state_nxt;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= P_IDLE;
    end else if (flush) begin
      state <= P_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The event strobe is Mealy so the queue captures it on the same edge as the byte.
  always_comb begin
    state_nxt = state;
    ev_valid  = 1'b0;
    ev_make   = 1'b0;
    ev_ext    = 1'b0;
    ev_code   = rx_data;
    if (rx_we) begin
      if (rx_data == KBD_PFX_EXT) begin
        state_nxt = P_EXT;
      end else if (rx_data == KBD_PFX_BRK) begin
        case (state)
          P_IDLE:  state_nxt = P_BRK;
          P_EXT:   state_nxt = P_EXT_BRK;
          default: state_nxt = state;
        endcase
      end else begin
        ev_valid  = 1'b1;
        ev_make   = (state == P_IDLE) || (state == P_EXT);
        ev_ext    = (state == P_EXT)  || (state == P_EXT_BRK);
        state_nxt = P_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/m_kbd_evq.sv
`default_nettype none
// ============================================================================
// m_kbd_evq : keyboard event queue with throttled, handshaked service requests
// Rev 1.0 : initial release
// ============================================================================
module m_kbd_evq
  import m_kbd_evq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TICK_BITS = 18,
  parameter int OVF_W     = 8
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic                     i_rx_we,
  input  logic [7:0]               i_rx_data,
  input  logic [63:0]              i_mtime,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_pop,
  output logic                     o_req,
  output logic [15:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [OVF_W-1:0]         o_ovf_cnt,
  output logic                     o_pending
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int ENTRY_W = EV_EXT + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic               ev_valid;
  logic               ev_make;
  logic               ev_ext;
  logic [7:0]         ev_code;
  logic [ENTRY_W-1:0] ev_entry;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      head_ptr;
  logic [PW-1:0]      tail_ptr;
  logic [CW-1:0]      count;
  logic [OVF_W-1:0]   ovf_cnt;
  logic               req;
  logic               pending;

  logic               tick;
  logic               full;
  logic               do_pop;
  logic               do_push;
  logic               drop;
  logic               qualify;
  logic               unused_mtime;

  m_kbd_scan_parser u_parser (
    .CLK      (CLK),
    .RST_X    (RST_X),
    .flush    (i_flush),
    .rx_we    (i_rx_we),
    .rx_data  (i_rx_data),
    .ev_valid (ev_valid),
    .ev_make  (ev_make),
    .ev_ext   (ev_ext),
    .ev_code  (ev_code)
  );

  always_comb begin
    ev_entry          = '0;
    ev_entry[7:0]     = ev_code;
    ev_entry[EV_MAKE] = ev_make;
    ev_entry[EV_EXT]  = ev_ext;
  end

  assign unused_mtime = ^i_mtime[63:TICK_BITS];
  assign tick         = (i_mtime[TICK_BITS-1:0] == '0);
  assign full         = (count == FULL_CNT);
  assign do_pop       = i_pop && (count != '0) && !i_flush;
  // A pop on a full queue frees the slot the simultaneous push lands in.
  assign do_push      = ev_valid && (!full || do_pop) && !i_flush;
  assign drop         = ev_valid && full && !do_pop && !i_flush;
  // Excluding the pop cycle forces the next request to wait for a fresh tick.
  assign qualify      = tick && i_enable && (count != '0) && !pending
                        && !i_pop && !i_flush;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[tail_ptr] <= ev_entry;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      ovf_cnt  <= '0;
      req      <= 1'b0;
      pending  <= 1'b0;
    end else if (i_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      ovf_cnt  <= '0;
      req      <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (do_push) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
      req <= qualify;
      if (i_pop) begin
        pending <= 1'b0;
      end else if (qualify) begin
        pending <= 1'b1;
      end
    end
  end

  // Head slot is only rewritten by a push that coincides with its own pop.
  assign o_head    = (count != '0) ? {{(16-ENTRY_W){1'b0}}, mem[head_ptr]} : 16'h0000;
  assign o_count   = count;
  assign o_ovf_cnt = ovf_cnt;
  assign o_req     = req;
  assign o_pending = pending;

endmodule
`default_nettype wire

// File: tb/tb_m_kbd_evq.sv
`default_nettype none
// ============================================================================
// tb_m_kbd_evq : directed self-checking bench for m_kbd_evq (DEPTH=4)
// Rev 1.0 : initial release
// ============================================================================
module tb_m_kbd_evq;

  localparam int DEPTH     = 4;
  localparam int TICK_BITS = 4;
  localparam int OVF_W     = 8;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        i_rx_we;
  logic [7:0]  i_rx_data;
  logic [63:0] i_mtime;
  logic        i_enable;
  logic        i_flush;
  logic        i_pop;
  logic        o_req;
  logic [15:0] o_head;
  logic [2:0]  o_count;
  logic [7:0]  o_ovf_cnt;
  logic        o_pending;

  int checks = 0;
  int errors = 0;

  m_kbd_evq #(.DEPTH(DEPTH), .TICK_BITS(TICK_BITS), .OVF_W(OVF_W)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .i_rx_we   (i_rx_we),
    .i_rx_data (i_rx_data),
    .i_mtime   (i_mtime),
    .i_enable  (i_enable),
    .i_flush   (i_flush),
    .i_pop     (i_pop),
    .o_req     (o_req),
    .o_head    (o_head),
    .o_count   (o_count),
    .o_ovf_cnt (o_ovf_cnt),
    .o_pending (o_pending)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_we   = 1'b1;
    i_rx_data = b;
    step();
    i_rx_we   = 1'b0;
  endtask

  task automatic do_tick();
    i_mtime = 64'h0;
    step();
    i_mtime = 64'h1;
  endtask

  task automatic do_pop();
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_req); end
    checks++; if (o_head !== 16'h0) begin errors++; $display("FAIL reset_head: got %h want 0000", o_head); end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    checks++; if (o_ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", o_ovf_cnt); end
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", o_pending); end
    RST_X = 1'b1;
    step();
  endtask

  task automatic test_parse();
    logic [15:0] exp;
    i_enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin send_byte(8'h1C); exp = 16'h011C; end
        1: begin send_byte(8'hF0); send_byte(8'h1C); exp = 16'h001C; end
        2: begin send_byte(8'hE0); send_byte(8'h75); exp = 16'h0375; end
        default: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); exp = 16'h0275; end
      endcase
      checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL parse_count[%0d]: got %0d want 1", s, o_count); end
      do_tick();
      checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL parse_req[%0d]: got %b want 1", s, o_req); end
      checks++; if (o_head !== exp) begin errors++; $display("FAIL parse_head[%0d]: got %h want %h", s, o_head, exp); end
      step();
      checks++; if (o_req !== 1'b0 || o_pending !== 1'b1) begin errors++; $display("FAIL parse_req_pulse[%0d]: got req=%b pend=%b want req=0 pend=1", s, o_req, o_pending); end
      do_pop();
      checks++; if (o_count !== 3'd0 || o_pending !== 1'b0) begin errors++; $display("FAIL parse_pop[%0d]: got count=%0d pend=%b want 0 0", s, o_count, o_pending); end
    end
    do_pop();
    checks++; if (o_count !== 3'd0 || o_head !== 16'h0) begin errors++; $display("FAIL pop_empty: got count=%0d head=%h want 0 0000", o_count, o_head); end
  endtask

  task automatic test_overflow();
    i_enable = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
    checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", o_count); end
    checks++; if (o_ovf_cnt !== 8'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", o_ovf_cnt); end
    checks++; if (o_head !== 16'h0110) begin errors++; $display("FAIL ovf_head: got %h want 0110", o_head); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp;
    i_pop = 1'b1;
    send_byte(8'h20);
    i_pop = 1'b0;
    checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL fullpp_count: got %0d want 4", o_count); end
    checks++; if (o_ovf_cnt !== 8'd2) begin errors++; $display("FAIL fullpp_ovf: got %0d want 2", o_ovf_cnt); end
    for (int i = 0; i < 4; i++) begin
      exp = (i == 3) ? 16'h0120 : (16'h0111 + 16'(i));
      checks++; if (o_head !== exp) begin errors++; $display("FAIL fullpp_head[%0d]: got %h want %h", i, o_head, exp); end
      do_pop();
    end
    checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL fullpp_drain: got %0d want 0", o_count); end
  endtask

  task automatic test_handshake();
    int pulses;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    checks++; if (o_ovf_cnt !== 8'd0) begin errors++; $display("FAIL flush_ovf: got %0d want 0", o_ovf_cnt); end
    i_enable = 1'b1;
    send_byte(8'h1C);
    send_byte(8'h1D);
    pulses = 0;
    for (int t = 0; t < 3; t++) begin
      do_tick();
      if (o_req === 1'b1) pulses++;
      step();
      if (o_req === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hs_one_req: got %0d pulses want 1", pulses); end
    checks++; if (o_pending !== 1'b1 || o_head !== 16'h011C) begin errors++; $display("FAIL hs_pending: got pend=%b head=%h want 1 011C", o_pending, o_head); end
    do_pop();
    checks++; if (o_pending !== 1'b0 || o_count !== 3'd1 || o_head !== 16'h011D) begin errors++; $display("FAIL hs_pop: got pend=%b count=%0d head=%h want 0 1 011D", o_pending, o_count, o_head); end
    step();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL hs_no_tick: got %b want 0", o_req); end
    do_tick();
    checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL hs_second_req: got %b want 1", o_req); end
    do_pop();
  endtask

  task automatic test_enable();
    int pulses;
    i_enable = 1'b0;
    send_byte(8'h1E);
    pulses = 0;
    for (int t = 0; t < 2; t++) begin
      do_tick();
      if (o_req === 1'b1 || o_pending === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL en_gated: got %0d requests want 0", pulses); end
    i_enable = 1'b1;
    step();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL en_wait_tick: got %b want 0", o_req); end
    do_tick();
    checks++; if (o_req !== 1'b1 || o_head !== 16'h011E) begin errors++; $display("FAIL en_req: got req=%b head=%h want 1 011E", o_req, o_head); end
    do_pop();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1C);
    do_tick();
    send_byte(8'hE0);
    send_byte(8'hF0);
    #2 RST_X = 1'b0;
    #1;
    checks++; if (o_req !== 1'b0 || o_head !== 16'h0 || o_count !== 3'd0 || o_ovf_cnt !== 8'd0 || o_pending !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%b head=%h count=%0d ovf=%0d pend=%b want all 0", o_req, o_head, o_count, o_ovf_cnt, o_pending);
    end
    #3 RST_X = 1'b1;
    step();
    send_byte(8'h1C);
    checks++; if (o_head !== 16'h011C || o_count !== 3'd1) begin errors++; $display("FAIL post_reset_parse: got head=%h count=%0d want 011C 1", o_head, o_count); end
  endtask

  task automatic test_flush();
    send_byte(8'h2A);
    send_byte(8'h2B);
    do_tick();
    checks++; if (o_count !== 3'd3 || o_pending !== 1'b1) begin errors++; $display("FAIL flush_setup: got count=%0d pend=%b want 3 1", o_count, o_pending); end
    i_flush   = 1'b1;
    i_rx_we   = 1'b1;
    i_rx_data = 8'h2C;
    i_pop     = 1'b1;
    step();
    i_flush = 1'b0;
    i_rx_we = 1'b0;
    i_pop   = 1'b0;
    checks++; if (o_count !== 3'd0 || o_pending !== 1'b0 || o_req !== 1'b0 || o_head !== 16'h0) begin
      errors++; $display("FAIL flush: got count=%0d pend=%b req=%b head=%h want 0 0 0 0000", o_count, o_pending, o_req, o_head);
    end
  endtask

  initial begin
    RST_X     = 1'b0;
    i_rx_we   = 1'b0;
    i_rx_data = 8'h00;
    i_mtime   = 64'h1;
    i_enable  = 1'b0;
    i_flush   = 1'b0;
    i_pop     = 1'b0;
    test_reset();
    test_parse();
    test_overflow();
    test_full_push_pop();
    test_handshake();
    test_enable();
    test_reset_mid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
